// File: rtl/ajc_risc_dp_pkg.sv
// ajc_risc_dp_pkg
// Shared definitions for the parameterised RISC datapath:
//   - ALU function codes (alu_fs)
//   - write-back bus source codes (wb_sel)
//   - memory sequencer state enum
//   - bit positions of C, N, V, Z inside the status register
package ajc_risc_dp_pkg;

  // ALU function codes; 4'hD..4'hF give a zero result
  localparam logic [3:0] FS_PASS = 4'h0;
  localparam logic [3:0] FS_ADD  = 4'h1;
  localparam logic [3:0] FS_ADC  = 4'h2;
  localparam logic [3:0] FS_SUB  = 4'h3;
  localparam logic [3:0] FS_AND  = 4'h4;
  localparam logic [3:0] FS_OR   = 4'h5;
  localparam logic [3:0] FS_XOR  = 4'h6;
  localparam logic [3:0] FS_NOT  = 4'h7;
  localparam logic [3:0] FS_SHL  = 4'h8;
  localparam logic [3:0] FS_SHR  = 4'h9;
  localparam logic [3:0] FS_SAR  = 4'hA;
  localparam logic [3:0] FS_INC  = 4'hB;
  localparam logic [3:0] FS_DEC  = 4'hC;

  // Write-back bus sources
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DMR  = 2'd1;
  localparam logic [1:0] WB_IPDR = 2'd2;
  localparam logic [1:0] WB_ZERO = 2'd3;

  // Status register bit positions, SR = {C,N,V,Z}
  localparam int SR_C = 3;
  localparam int SR_N = 2;
  localparam int SR_V = 1;
  localparam int SR_Z = 0;

  // Memory sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_REQ  = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/ajc_risc_dp_param_if.sv
// ajc_risc_dp_param_if
// Data-memory bus between the datapath's memory sequencer and a memory.
//   req   : access request, held high until ack
//   we    : 1 store, 0 load (stable while req)
//   addr  : word address (stable while req)
//   wdata : store data (stable while req)
//   ack   : memory completion, sampled only while req is high
//   rdata : load data, sampled on the ack edge
// Modports: master = datapath side, slave = memory side.
interface ajc_risc_dp_param_if #(
  parameter int DW = 8,
  parameter int AW = 10
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/ajc_risc_alu.sv
// ajc_risc_alu
// Combinational ALU of the datapath.
//   x, y   : operands (x = SRC1, y = SRC2)
//   c_in   : carry in for add-with-carry
//   fs     : function select (FS_* codes)
//   result : ALU result
//   cnvz   : flags {C,N,V,Z}; C is borrow on SUB/DEC, the shifted-out bit on
//            shifts, 0 on logic ops; V only on ADD/ADC/SUB/INC/DEC
module ajc_risc_alu
  import ajc_risc_dp_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          c_in,
  input  logic [3:0]    fs,
  output logic [DW-1:0] result,
  output logic [3:0]    cnvz
);

  logic [DW:0]   wide;
  logic [DW-1:0] res;
  logic          c_flag;
  logic          v_flag;

  always_comb begin
    wide   = '0;
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (fs)
      FS_PASS: res = x;
      FS_ADD: begin
        wide   = {1'b0, x} + {1'b0, y};
        res    = wide[DW-1:0];
        c_flag = wide[DW];
        v_flag = (x[DW-1] == y[DW-1]) && (res[DW-1] != x[DW-1]);
      end
      FS_ADC: begin
        wide   = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, c_in};
        res    = wide[DW-1:0];
        c_flag = wide[DW];
        v_flag = (x[DW-1] == y[DW-1]) && (res[DW-1] != x[DW-1]);
      end
      FS_SUB: begin
        // The extra top bit of the widened difference is the borrow
        wide   = {1'b0, x} - {1'b0, y};
        res    = wide[DW-1:0];
        c_flag = wide[DW];
        v_flag = (x[DW-1] != y[DW-1]) && (res[DW-1] != x[DW-1]);
      end
      FS_AND: res = x & y;
      FS_OR:  res = x | y;
      FS_XOR: res = x ^ y;
      FS_NOT: res = ~x;
      FS_SHL: begin
        res    = {x[DW-2:0], 1'b0};
        c_flag = x[DW-1];
      end
      FS_SHR: begin
        res    = {1'b0, x[DW-1:1]};
        c_flag = x[0];
      end
      FS_SAR: begin
        res    = {x[DW-1], x[DW-1:1]};
        c_flag = x[0];
      end
      FS_INC: begin
        wide   = {1'b0, x} + (DW+1)'(1);
        res    = wide[DW-1:0];
        c_flag = wide[DW];
        v_flag = ~x[DW-1] & res[DW-1];
      end
      FS_DEC: begin
        wide   = {1'b0, x} - (DW+1)'(1);
        res    = wide[DW-1:0];
        c_flag = wide[DW];
        v_flag = x[DW-1] & ~res[DW-1];
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    cnvz       = '0;
    cnvz[SR_C] = c_flag;
    cnvz[SR_N] = res[DW-1];
    cnvz[SR_V] = v_flag;
    cnvz[SR_Z] = (res == '0);
  end

  assign result = res;

endmodule

// File: rtl/ajc_risc_dp_param.sv
// ajc_risc_dp_param
// Parameterised RISC datapath: NREG x DW register file, ALU with CNVZ status
// register, input/output port registers and a data-memory sequencer
// (IDLE -> ADDR -> REQ -> DONE).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rf_we, rf_wa               register-file write enable / address
//   src1_sel, src2_sel         operand X / Y read addresses
//   wb_sel                     write-back source (ALU, DMR, IPDR, zero)
//   alu_fs, ld_sr              ALU function, status-register load
//   ld_ipdr, ld_opdr           port register loads
//   in_port, out_port          input port, OPDR contents
//   sr_cnvz                    status register {C,N,V,Z}
//   mem_start, mem_wr, mem_ofs memory access start, direction, signed offset
//   mem_busy, mem_done         sequencer busy, one-cycle completion pulse
//   mem_err                    sticky timeout flag
//   dm                         data-memory bus (master side)
// Build option: define AJC_DP_MEM_TIMEOUT_EN to abort a memory request after
// TMO_CYC unacknowledged REQ cycles and flag mem_err; without it REQ waits
// for ack indefinitely and mem_err is constant 0.
module ajc_risc_dp_param
  import ajc_risc_dp_pkg::*;
#(
  parameter int DW      = 8,
  parameter int NREG    = 4,
  parameter int AW      = 10,
  parameter int TMO_CYC = 16,
  localparam int RAW    = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rf_we,
  input  logic [RAW-1:0] rf_wa,
  input  logic [RAW-1:0] src1_sel,
  input  logic [RAW-1:0] src2_sel,
  input  logic [1:0]     wb_sel,
  input  logic [3:0]     alu_fs,
  input  logic           ld_sr,
  input  logic           ld_ipdr,
  input  logic           ld_opdr,
  input  logic [DW-1:0]  in_port,
  output logic [DW-1:0]  out_port,
  output logic [3:0]     sr_cnvz,
  input  logic           mem_start,
  input  logic           mem_wr,
  input  logic [AW-1:0]  mem_ofs,
  output logic           mem_busy,
  output logic           mem_done,
  output logic           mem_err,
  ajc_risc_dp_param_if.master dm
);

  if (DW < 4 || NREG < 2 || (NREG & (NREG - 1)) != 0 || AW <= DW || TMO_CYC < 1)
  begin : g_param_check
    $error("ajc_risc_dp_param: illegal parameter combination");
  end

  // Architectural state
  logic [DW-1:0] rf_reg [NREG];
  logic [DW-1:0] dmr_reg;
  logic [DW-1:0] ipdr_reg;
  logic [DW-1:0] opdr_reg;
  logic [3:0]    sr_reg;

  // Memory cycle registers
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic          we_reg;

  mem_state_e    state_reg, state_next;

  logic [DW-1:0] op_x, op_y;
  logic [DW-1:0] alu_result;
  logic [3:0]    alu_cnvz;
  logic [DW-1:0] wb_bus;
  logic [AW-1:0] addr_next;
  logic          start_accept;
  logic          ack_accept;
  logic          tmo_hit;

  // Register file: combinational read, no write-to-read bypass
  assign op_x = rf_reg[src1_sel];
  assign op_y = rf_reg[src2_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else if (rf_we) begin
      rf_reg[rf_wa] <= wb_bus;
    end
  end

  ajc_risc_alu #(.DW(DW)) u_alu (
    .x      (op_x),
    .y      (op_y),
    .c_in   (sr_reg[SR_C]),
    .fs     (alu_fs),
    .result (alu_result),
    .cnvz   (alu_cnvz)
  );

  always_comb begin
    wb_bus = '0;
    case (wb_sel)
      WB_ALU:  wb_bus = alu_result;
      WB_DMR:  wb_bus = dmr_reg;
      WB_IPDR: wb_bus = ipdr_reg;
      default: wb_bus = '0;
    endcase
  end

  // Status and port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg   <= '0;
      ipdr_reg <= '0;
      opdr_reg <= '0;
    end else begin
      if (ld_sr)   sr_reg   <= alu_cnvz;
      if (ld_ipdr) ipdr_reg <= in_port;
      if (ld_opdr) opdr_reg <= op_x;
    end
  end

  assign out_port = opdr_reg;
  assign sr_cnvz  = sr_reg;

  // Base register is treated as signed; the sum wraps modulo 2^AW
  assign addr_next = {{(AW-DW){op_x[DW-1]}}, op_x} + mem_ofs;

  assign start_accept = (state_reg == ST_IDLE) && mem_start;
  assign ack_accept   = (state_reg == ST_REQ) && dm.ack;

`ifdef AJC_DP_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          err_reg;

  // tmo_cnt_reg counts completed unacknowledged REQ cycles
  assign tmo_hit = (state_reg == ST_REQ) && !dm.ack &&
                   (tmo_cnt_reg == TW'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (state_reg == ST_REQ && !dm.ack && !tmo_hit) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      else tmo_cnt_reg <= '0;
      if (start_accept) err_reg <= 1'b0;
      else if (tmo_hit) err_reg <= 1'b1;
    end
  end

  assign mem_err = err_reg;
`else
  assign tmo_hit = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Sequencer next state and outputs
  always_comb begin
    state_next = state_reg;
    mem_busy   = 1'b1;
    mem_done   = 1'b0;
    dm.req     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        mem_busy = 1'b0;
        if (mem_start) state_next = ST_ADDR;
      end
      ST_ADDR: state_next = ST_REQ;
      ST_REQ: begin
        dm.req = 1'b1;
        if (dm.ack || tmo_hit) state_next = ST_DONE;
      end
      ST_DONE: begin
        mem_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address/data/direction are captured once at start and held to the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      dmr_reg   <= '0;
    end else begin
      if (start_accept) begin
        addr_reg  <= addr_next;
        wdata_reg <= op_y;
        we_reg    <= mem_wr;
      end
      if (ack_accept && !we_reg) dmr_reg <= dm.rdata;
    end
  end

  assign dm.addr  = addr_reg;
  assign dm.wdata = wdata_reg;
  assign dm.we    = we_reg;

endmodule

// File: tb/tb_ajc_risc_dp_param.sv
module tb_ajc_risc_dp_param;
  import ajc_risc_dp_pkg::*;

  localparam int DW = 8, NREG = 4, AW = 10, TMO_CYC = 4, RAW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rf_we = 1'b0;
  logic [RAW-1:0] rf_wa = '0, src1_sel = '0, src2_sel = '0;
  logic [1:0]     wb_sel = WB_ZERO;
  logic [3:0]     alu_fs = FS_PASS;
  logic           ld_sr = 1'b0, ld_ipdr = 1'b0, ld_opdr = 1'b0;
  logic [DW-1:0]  in_port = '0;
  logic [DW-1:0]  out_port;
  logic [3:0]     sr_cnvz;
  logic           mem_start = 1'b0, mem_wr = 1'b0;
  logic [AW-1:0]  mem_ofs = '0;
  logic           mem_busy, mem_done, mem_err;

  ajc_risc_dp_param_if #(.DW(DW), .AW(AW)) dm_bus ();

  ajc_risc_dp_param #(.DW(DW), .NREG(NREG), .AW(AW), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .rf_we(rf_we), .rf_wa(rf_wa),
    .src1_sel(src1_sel), .src2_sel(src2_sel), .wb_sel(wb_sel),
    .alu_fs(alu_fs), .ld_sr(ld_sr), .ld_ipdr(ld_ipdr), .ld_opdr(ld_opdr),
    .in_port(in_port), .out_port(out_port), .sr_cnvz(sr_cnvz),
    .mem_start(mem_start), .mem_wr(mem_wr), .mem_ofs(mem_ofs),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
    .dm(dm_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] xv;
    logic [7:0] yv;
    logic       cin;
    logic [3:0] fs;
    logic [7:0] exp_res;
    logic [3:0] exp_cnvz;
  } alu_vec_t;

  alu_vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [RAW-1:0] a, input logic [7:0] v);
    in_port = v; ld_ipdr = 1'b1;
    tick();
    ld_ipdr = 1'b0; wb_sel = WB_IPDR; rf_we = 1'b1; rf_wa = a;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic read_reg(input logic [RAW-1:0] a, output logic [7:0] v);
    src1_sel = a; ld_opdr = 1'b1;
    tick();
    ld_opdr = 1'b0;
    v = out_port;
  endtask

  logic [7:0] rd;
  int done_cyc;
  logic saw_done;

  initial begin
    vecs[0]  = '{8'h7F, 8'h01, 1'b0, FS_ADD,  8'h80, 4'b0110};
    vecs[1]  = '{8'h00, 8'h01, 1'b0, FS_SUB,  8'hFF, 4'b1100};
    vecs[2]  = '{8'h00, 8'h00, 1'b1, FS_ADC,  8'h01, 4'b0000};
    vecs[3]  = '{8'hF0, 8'h3C, 1'b0, FS_AND,  8'h30, 4'b0000};
    vecs[4]  = '{8'hF0, 8'h0F, 1'b1, FS_OR,   8'hFF, 4'b0100};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b0, FS_XOR,  8'h00, 4'b0001};
    vecs[6]  = '{8'h0F, 8'h00, 1'b0, FS_NOT,  8'hF0, 4'b0100};
    vecs[7]  = '{8'h81, 8'h00, 1'b0, FS_SHL,  8'h02, 4'b1000};
    vecs[8]  = '{8'h81, 8'h00, 1'b0, FS_SHR,  8'h40, 4'b1000};
    vecs[9]  = '{8'h81, 8'h00, 1'b0, FS_SAR,  8'hC0, 4'b1100};
    vecs[10] = '{8'h7F, 8'h00, 1'b0, FS_INC,  8'h80, 4'b0110};
    vecs[11] = '{8'h00, 8'h00, 1'b0, FS_DEC,  8'hFF, 4'b1100};
    vecs[12] = '{8'h80, 8'h00, 1'b0, FS_DEC,  8'h7F, 4'b0010};
    vecs[13] = '{8'hFF, 8'h01, 1'b0, FS_ADD,  8'h00, 4'b1001};
    vecs[14] = '{8'h80, 8'h01, 1'b0, FS_SUB,  8'h7F, 4'b0010};
    vecs[15] = '{8'h55, 8'h11, 1'b0, 4'hD,    8'h00, 4'b0001};
    vecs[16] = '{8'hA5, 8'h00, 1'b0, FS_PASS, 8'hA5, 4'b0100};
    vecs[17] = '{8'hFF, 8'hFF, 1'b1, FS_ADC,  8'hFF, 4'b1100};

    dm_bus.ack = 1'b0;
    dm_bus.rdata = '0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("rst_out_port", out_port, 0);
    check("rst_sr", sr_cnvz, 0);
    check("rst_busy", mem_busy, 0);
    check("rst_done", mem_done, 0);
    check("rst_err", mem_err, 0);
    check("rst_req", dm_bus.req, 0);
    check("rst_addr", dm_bus.addr, 0);
    check("rst_we", dm_bus.we, 0);
    check("rst_wdata", dm_bus.wdata, 0);
    rst_n = 1'b1;
    tick();
    read_reg(2'd3, rd);
    check("rst_r3", rd, 0);

    // ---------------- ALU vectors ----------------
    for (int i = 0; i < 18; i++) begin
      write_reg(2'd1, vecs[i].xv);
      write_reg(2'd2, vecs[i].yv);
      write_reg(2'd3, vecs[i].cin ? 8'h80 : 8'h00);
      // Seed C: shifting R3 left moves the chosen bit into carry
      src1_sel = 2'd3; alu_fs = FS_SHL; ld_sr = 1'b1;
      tick();
      src1_sel = 2'd1; src2_sel = 2'd2; alu_fs = vecs[i].fs;
      wb_sel = WB_ALU; rf_we = 1'b1; rf_wa = 2'd0;
      tick();
      ld_sr = 1'b0; rf_we = 1'b0;
      check($sformatf("vec%0d_cnvz", i), sr_cnvz, vecs[i].exp_cnvz);
      read_reg(2'd0, rd);
      check($sformatf("vec%0d_res", i), rd, vecs[i].exp_res);
      $display("alu vec %0d fs=%h x=%h y=%h c=%b -> res=%h cnvz=%b",
               i, vecs[i].fs, vecs[i].xv, vecs[i].yv, vecs[i].cin, rd, sr_cnvz);
    end

    // SR holds when ld_sr is low (last SR = 1100 from vec17)
    src1_sel = 2'd1; src2_sel = 2'd2; alu_fs = FS_XOR; ld_sr = 1'b0;
    tick();
    check("sr_hold", sr_cnvz, 4'b1100);
    $display("sr hold: cnvz=%b", sr_cnvz);

    // Same-cycle write/read of R0 returns the old value (R0 = 0xFF)
    src1_sel = 2'd0; ld_opdr = 1'b1; wb_sel = WB_ZERO; rf_we = 1'b1; rf_wa = 2'd0;
    tick();
    ld_opdr = 1'b0; rf_we = 1'b0;
    check("no_bypass_old", out_port, 8'hFF);
    read_reg(2'd0, rd);
    check("no_bypass_new", rd, 8'h00);
    $display("no-bypass: old=%h new=%h", 8'hFF, rd);

    // ---------------- load sequence ----------------
    write_reg(2'd1, 8'hFE);
    src1_sel = 2'd1; mem_ofs = 10'h004; mem_wr = 1'b0; mem_start = 1'b1;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      mem_start = 1'b0;
      if (cyc == 1) begin
        check("ld_addr", dm_bus.addr, 10'h002);
        check("ld_we", dm_bus.we, 0);
        check("ld_busy_addr", mem_busy, 1);
        check("ld_req_addr", dm_bus.req, 0);
      end
      if (cyc == 2) check("ld_req_rise", dm_bus.req, 1);
      if (cyc == 4) begin
        dm_bus.ack = 1'b1; dm_bus.rdata = 8'h5A;
      end
      if (mem_done) begin
        done_cyc = cyc;
        dm_bus.ack = 1'b0;
        break;
      end
    end
    check("ld_done_cycle", done_cyc, 5);
    tick();
    check("ld_done_pulse", mem_done, 0);
    check("ld_idle", mem_busy, 0);
    wb_sel = WB_DMR; rf_we = 1'b1; rf_wa = 2'd3;
    tick();
    rf_we = 1'b0;
    read_reg(2'd3, rd);
    check("ld_r3", rd, 8'h5A);
    $display("load: addr=0x002 done_cyc=%0d r3=%h", done_cyc, rd);

    // ---------------- store sequence ----------------
    write_reg(2'd1, 8'h7F);
    write_reg(2'd2, 8'h33);
    src1_sel = 2'd1; src2_sel = 2'd2; mem_ofs = 10'h3FF; mem_wr = 1'b1; mem_start = 1'b1;
    tick();
    mem_start = 1'b0;
    check("st_addr", dm_bus.addr, 10'h07E);
    check("st_we", dm_bus.we, 1);
    check("st_wdata", dm_bus.wdata, 8'h33);
    tick();
    check("st_req", dm_bus.req, 1);
    // A start request while busy must not disturb the access
    src1_sel = 2'd2; mem_ofs = 10'h000; mem_wr = 1'b0; mem_start = 1'b1;
    tick();
    mem_start = 1'b0;
    check("st_ign_addr", dm_bus.addr, 10'h07E);
    check("st_ign_we", dm_bus.we, 1);
    check("st_ign_req", dm_bus.req, 1);
    dm_bus.rdata = 8'hC3; dm_bus.ack = 1'b1;
    tick();
    dm_bus.ack = 1'b0;
    check("st_done", mem_done, 1);
    tick();
    check("st_done_pulse", mem_done, 0);
    check("st_no_restart", mem_busy, 0);
    wb_sel = WB_DMR; rf_we = 1'b1; rf_wa = 2'd0;
    tick();
    rf_we = 1'b0;
    read_reg(2'd0, rd);
    check("st_dmr_kept", rd, 8'h5A);
    $display("store: addr=%h we=%b wdata=%h dmr=%h", 10'h07E, 1'b1, 8'h33, rd);

    // ---------------- reset during REQ ----------------
    src1_sel = 2'd1; mem_wr = 1'b0; mem_ofs = 10'h001; mem_start = 1'b1;
    tick();
    mem_start = 1'b0;
    tick();
    check("rr_req_before", dm_bus.req, 1);
    rst_n = 1'b0;
    #1;
    check("rr_req", dm_bus.req, 0);
    check("rr_busy", mem_busy, 0);
    check("rr_addr", dm_bus.addr, 0);
    check("rr_sr", sr_cnvz, 0);
    check("rr_out", out_port, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (mem_done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (mem_done) saw_done = 1'b1;
    end
    check("rr_no_done", saw_done, 0);
    check("rr_idle", mem_busy, 0);
    read_reg(2'd3, rd);
    check("rr_r3_cleared", rd, 0);
    $display("reset in REQ: req=0 busy=0 no done");

    // ---------------- unacknowledged request ----------------
    write_reg(2'd1, 8'h10);
    write_reg(2'd3, 8'h77);
    wb_sel = WB_IPDR; rf_we = 1'b1; rf_wa = 2'd3;
    tick();
    rf_we = 1'b0;
    src1_sel = 2'd1; mem_ofs = 10'h000; mem_wr = 1'b0; mem_start = 1'b1;
    done_cyc = 0;
`ifdef AJC_DP_MEM_TIMEOUT_EN
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      mem_start = 1'b0;
      if (mem_done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("tmo_done_cycle", done_cyc, 6);
    check("tmo_err", mem_err, 1);
    tick();
    check("tmo_idle", mem_busy, 0);
    check("tmo_err_sticky", mem_err, 1);
    wb_sel = WB_DMR; rf_we = 1'b1; rf_wa = 2'd0;
    tick();
    rf_we = 1'b0;
    read_reg(2'd0, rd);
    check("tmo_dmr_kept", rd, 8'h00);
    mem_start = 1'b1;
    tick();
    mem_start = 1'b0;
    check("tmo_err_clear", mem_err, 0);
    tick();
    dm_bus.ack = 1'b1; dm_bus.rdata = 8'h11;
    tick();
    dm_bus.ack = 1'b0;
    check("tmo_second_done", mem_done, 1);
    tick();
    $display("timeout: done_cyc=%0d err cleared on restart", done_cyc);
`else
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      mem_start = 1'b0;
      if (mem_done) done_cyc = cyc;
    end
    check("wait_no_done", done_cyc, 0);
    check("wait_req", dm_bus.req, 1);
    check("wait_err", mem_err, 0);
    dm_bus.ack = 1'b1; dm_bus.rdata = 8'h99;
    tick();
    dm_bus.ack = 1'b0;
    check("wait_done", mem_done, 1);
    tick();
    wb_sel = WB_DMR; rf_we = 1'b1; rf_wa = 2'd0;
    tick();
    rf_we = 1'b0;
    read_reg(2'd0, rd);
    check("wait_dmr", rd, 8'h99);
    $display("no timeout: request waited, dmr=%h", rd);
`endif

    // Ack outside REQ is ignored
    dm_bus.ack = 1'b1; dm_bus.rdata = 8'hEE;
    repeat (2) tick();
    dm_bus.ack = 1'b0;
    check("ack_idle_done", mem_done, 0);
    check("ack_idle_busy", mem_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
